bilat_norm_div: RTL and testbench



---
 rtl/bilat_norm_div_if.sv | 47 ++++
 rtl/bilat_norm_div.sv | 216 +++++++++++++++++++++
 tb/tb_bilat_norm_div.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bilat_norm_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : bilat_norm_div_if
//  Description : Handshake bundle for the bilateral-filter normalisation
//                divider. The input side carries the numerator/denominator
//                pair and the output side carries the filtered pixel.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    in_valid  : numerator/denominator pair valid   (master -> slave)
//    in_ready  : divider can accept a pair          (slave  -> master)
//    num       : weighted pixel sum, NUM_W bits     (master -> slave)
//    den       : weight sum, DEN_W bits             (master -> slave)
//    out_valid : result valid                       (slave  -> master)
//    out_ready : downstream accepts result          (master -> slave)
//    pix       : quotient pixel, PIX_W bits         (slave  -> master)
//    sat       : result saturated to max            (slave  -> master)
//    div_zero  : denominator was zero               (slave  -> master)
//    busy      : divider not idle                   (slave  -> master)
// ============================================================================
interface bilat_norm_div_if #(
  parameter int NUM_W = 35,
  parameter int DEN_W = 27,
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NUM_W-1:0] num;
  logic [DEN_W-1:0] den;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] pix;
  logic             sat;
  logic             div_zero;
  logic             busy;

  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, pix, sat, div_zero, busy
  );

  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, pix, sat, div_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/bilat_norm_div.sv
`default_nettype none
// ============================================================================
//  Module      : bilat_norm_div
//  Description : Normalisation stage of the bilateral filter. Divides the
//                weighted pixel sum by the weight sum with an iterative
//                restoring divider (one quotient bit per clock, MSB first)
//                and returns an 8-bit pixel. Zero denominators and quotients
//                that would not fit in PIX_W bits are caught up front.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   : clock, rising edge
//    rst_n : synchronous active-low reset
//    bus   : bilat_norm_div_if.slave (in_valid/in_ready/num/den,
//            out_valid/out_ready/pix/sat/div_zero, busy)
//  Build option
//    BILAT_DIV_ROUND_EN : adds a ROUND state after the bit loop so the
//                         quotient is round-half-up instead of floor
//                         (normal-divide latency PIX_W+1 instead of PIX_W).
// ============================================================================
module bilat_norm_div #(
  parameter int NUM_W = 35,
  parameter int DEN_W = 27,
  parameter int PIX_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  bilat_norm_div_if.slave  bus
);

  localparam int c_HI_W  = NUM_W - PIX_W;
  localparam int c_CMP_W = (c_HI_W > DEN_W) ? c_HI_W : DEN_W;
  localparam int c_CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CALC  = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;
  localparam logic [1:0] c_ST_ROUND = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic [PIX_W-1:0]   r_num_lo;
  logic [DEN_W-1:0]   r_den;
  logic [DEN_W-1:0]   r_rem;
  logic [PIX_W-1:0]   r_q;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_special;
  logic [PIX_W-1:0]   r_pix;
  logic               r_sat;
  logic               r_div_zero;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  // Accept-time classification on the raw inputs.
  logic [c_HI_W-1:0]  w_num_hi;
  logic               w_den_zero;
  logic               w_ovf;
  logic               w_accept;

  assign w_num_hi   = bus.num[NUM_W-1:PIX_W];
  assign w_den_zero = (bus.den == '0);
  assign w_ovf      = c_CMP_W'(w_num_hi) >= c_CMP_W'(bus.den);
  assign w_accept   = bus.in_valid && w_in_ready;

  // One restoring step. The remainder is always below den, so shifting it
  // in DEN_W+1 bits can never overflow.
  logic [DEN_W:0]     w_rem_sh;
  logic               w_q_bit;
  logic [PIX_W-1:0]   w_q_nxt;
  logic               w_round_up;

  assign w_rem_sh   = {r_rem, r_num_lo[r_cnt]};
  assign w_q_bit    = (w_rem_sh >= {1'b0, r_den});
  assign w_q_nxt    = {r_q[PIX_W-2:0], w_q_bit};
  // Half-up: the next (fractional) quotient bit would be a one.
  assign w_round_up = ({r_rem, 1'b0} >= {1'b0, r_den});

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // Special cases (den==0 or saturating) still spend one cycle in CALC so
  // their result appears one clock after acceptance; no bits are computed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_ST_CALC;
        end
      end
      c_ST_CALC: begin
        if (r_special) begin
          w_state_nxt = c_ST_DONE;
        end else if (r_cnt == '0) begin
`ifdef BILAT_DIV_ROUND_EN
          w_state_nxt = c_ST_ROUND;
`else
          w_state_nxt = c_ST_DONE;
`endif
        end
      end
      c_ST_ROUND: begin
        w_state_nxt = c_ST_DONE;
      end
      c_ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      c_ST_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
      end
      c_ST_DONE: begin
        w_out_valid = 1'b1;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.pix       = r_pix;
  assign bus.sat       = r_sat;
  assign bus.div_zero  = r_div_zero;

  // --------------------------------------------------------------------------
  // Datapath
  // Only the low PIX_W numerator bits are kept: the high part seeds the
  // remainder at accept and is never needed again.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num_lo   <= '0;
      r_den      <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_special  <= 1'b0;
      r_pix      <= '0;
      r_sat      <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_num_lo   <= bus.num[PIX_W-1:0];
            r_den      <= bus.den;
            // Truncation is harmless: when it would matter, w_ovf is set
            // and the remainder is never used.
            r_rem      <= DEN_W'(w_num_hi);
            r_q        <= '0;
            r_cnt      <= c_CNT_W'(PIX_W - 1);
            r_special  <= w_den_zero || w_ovf;
            r_div_zero <= w_den_zero;
            r_sat      <= !w_den_zero && w_ovf;
            r_pix      <= (!w_den_zero && w_ovf) ? '1 : '0;
          end
        end
        c_ST_CALC: begin
          if (!r_special) begin
            r_rem <= w_q_bit ? DEN_W'(w_rem_sh - {1'b0, r_den})
                             : w_rem_sh[DEN_W-1:0];
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - 1'b1;
`ifndef BILAT_DIV_ROUND_EN
            if (r_cnt == '0) begin
              r_pix <= w_q_nxt;
            end
`endif
          end
        end
        c_ST_ROUND: begin
          // Saturate at all-ones; sat only reflects the accept-time check.
          r_pix <= (w_round_up && (r_q != '1)) ? r_q + 1'b1 : r_q;
        end
        default: begin
          r_pix <= r_pix;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bilat_norm_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bilat_norm_div
//  Description : Directed self-checking bench for bilat_norm_div. Expected
//                quotients, flags and latencies are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bilat_norm_div;

  localparam int NUM_W = 35;
  localparam int DEN_W = 27;
  localparam int PIX_W = 8;

`ifdef BILAT_DIV_ROUND_EN
  localparam int c_LAT_N   = 9;
  localparam int c_P_200_3 = 67;
`else
  localparam int c_LAT_N   = 8;
  localparam int c_P_200_3 = 66;
`endif
  localparam int c_LAT_S   = 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bilat_norm_div_if #(.NUM_W(NUM_W), .DEN_W(DEN_W), .PIX_W(PIX_W)) bus ();

  bilat_norm_div #(.NUM_W(NUM_W), .DEN_W(DEN_W), .PIX_W(PIX_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, keep in_valid high with junk data while busy (must be
  // ignored), measure the latency and check the result and handshake.
  task automatic run_div(input string tag, input logic [NUM_W-1:0] n,
                         input logic [DEN_W-1:0] d, input int exp_pix,
                         input int exp_sat, input int exp_dz,
                         input int exp_lat, input int hold);
    int lat;
    check({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.num       = n;
    bus.den       = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    tick();
    bus.num = '1;
    bus.den = 27'd1;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_lat"},      32'(lat),          32'(exp_lat));
    check({tag, "_pix"},      32'(bus.pix),      32'(exp_pix));
    check({tag, "_sat"},      32'(bus.sat),      32'(exp_sat));
    check({tag, "_div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_pix"},   32'(bus.pix),       32'(exp_pix));
      check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_pix",       32'(bus.pix),       32'd0);
    check("rst_sat",       32'(bus.sat),       32'd0);
    check("rst_div_zero",  32'(bus.div_zero),  32'd0);

    run_div("d400_4",     35'd400,   27'd4,   100,       0, 0, c_LAT_N, 0);
    run_div("d200_3",     35'd200,   27'd3,   c_P_200_3, 0, 0, c_LAT_N, 0);
    run_div("d300_1",     35'd300,   27'd1,   255,       1, 0, c_LAT_S, 0);
    run_div("d65535_256", 35'd65535, 27'd256, 255,       0, 0, c_LAT_N, 0);
    run_div("d12345_0",   35'd12345, 27'd0,   0,         0, 1, c_LAT_S, 0);
    run_div("bp1020_4",   35'd1020,  27'd4,   255,       0, 0, c_LAT_N, 5);

    // Reset while dividing: accept at edge 0, reset sampled at edge 4.
    bus.num      = 35'd400;
    bus.den      = 27'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (6) tick();
    check("midrst_no_result", 32'(bus.out_valid), 32'd0);

    run_div("d1000_10", 35'd1000, 27'd10, 100, 0, 0, c_LAT_N, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
